// File: rtl/spi_auto_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// spi_auto_xfer_ctrl : runs SPI auto-read/auto-write commands as single-beat
// Avalon-MM transfers between the SPI rx/tx buffers and the AVMM fabric.
// Revision: 1.0
// ============================================================================
module spi_auto_xfer_ctrl #(
  parameter int BUF_SIZE    = 256,
  parameter int BUF_ADWIDTH = $clog2(BUF_SIZE),
  parameter int TIMEOUT     = 255
) (
  input  logic                   avmm_clk,
  input  logic                   rst_avmm_clk,
  input  logic                   auto_update,
  input  logic [31:0]            auto_csr0_reg,
  output logic [18:0]            avmm_addr,
  output logic                   avmm_read,
  output logic                   avmm_write,
  output logic [3:0]             avmm_byteenable,
  output logic [31:0]            avmm_wdata,
  input  logic [31:0]            avmm_rdata,
  input  logic                   avmm_rdatavalid,
  input  logic                   avmm_waitrequest,
  output logic                   rx_buf_re,
  output logic [BUF_ADWIDTH-1:0] rx_buf_raddr,
  input  logic [31:0]            rx_buf_rdata,
  output logic                   tx_buf_we,
  output logic [BUF_ADWIDTH-1:0] tx_buf_waddr,
  output logic [31:0]            tx_buf_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout,
  output logic                   err_overrun
);

  localparam int                TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_RSP   = 3'd2,
    WR_FETCH = 3'd3,
    WR_LOAD  = 3'd4,
    WR_REQ   = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t                 state_q;
  logic [16:0]            dw_addr_q;
  logic [16:0]            dw_addr_d;
  logic [BUF_ADWIDTH-1:0] len_q;
  logic [BUF_ADWIDTH-1:0] beat_q;
  logic [BUF_ADWIDTH-1:0] beat_d;
  logic [TW-1:0]          tcnt_q;
  logic                   rd_q;
  logic                   wr_q;
  logic [31:0]            wdata_q;
  logic                   rx_re_q;
  logic [BUF_ADWIDTH-1:0] rx_raddr_q;
  logic                   tx_we_q;
  logic [BUF_ADWIDTH-1:0] tx_waddr_q;
  logic [31:0]            tx_wdata_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   tmo_q;
  logic                   ovr_q;
  logic                   last_beat;
  logic                   tmo_hit;
  logic                   unused_csr;

  assign dw_addr_d  = dw_addr_q + 17'd1;
  assign beat_d     = beat_q + BUF_ADWIDTH'(1);
  assign last_beat  = (beat_q == len_q);
  assign tmo_hit    = (tcnt_q == TMO_LAST);
  assign unused_csr = ^{auto_csr0_reg[31:BUF_ADWIDTH+21], auto_csr0_reg[3:2]};

  always_ff @(posedge avmm_clk or posedge rst_avmm_clk) begin
    if (rst_avmm_clk) begin
      state_q    <= IDLE;
      dw_addr_q  <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      tcnt_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      rx_re_q    <= 1'b0;
      rx_raddr_q <= '0;
      tx_we_q    <= 1'b0;
      tx_waddr_q <= '0;
      tx_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      tx_we_q <= 1'b0;
      rx_re_q <= 1'b0;
      done_q  <= 1'b0;
      if (auto_update && (state_q != IDLE)) ovr_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (auto_update && auto_csr0_reg[0]) begin
            dw_addr_q <= auto_csr0_reg[20:4];
            len_q     <= auto_csr0_reg[BUF_ADWIDTH+20:21];
            beat_q    <= '0;
            tcnt_q    <= '0;
            busy_q    <= 1'b1;
            tmo_q     <= 1'b0;
            ovr_q     <= 1'b0;
            if (auto_csr0_reg[1]) begin
              rd_q    <= 1'b1;
              state_q <= RD_REQ;
            end else begin
              rx_re_q    <= 1'b1;
              rx_raddr_q <= '0;
              state_q    <= WR_FETCH;
            end
          end
        end
        RD_REQ: begin
          if (!avmm_waitrequest) begin
            rd_q    <= 1'b0;
            tcnt_q  <= '0;
            state_q <= RD_RSP;
          end else if (tmo_hit) begin
            rd_q    <= 1'b0;
            tmo_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        RD_RSP: begin
          if (avmm_rdatavalid) begin
            tx_we_q    <= 1'b1;
            tx_waddr_q <= beat_q;
            tx_wdata_q <= avmm_rdata;
            if (last_beat) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              beat_q    <= beat_d;
              dw_addr_q <= dw_addr_d;
              tcnt_q    <= '0;
              rd_q      <= 1'b1;
              state_q   <= RD_REQ;
            end
          end else if (tmo_hit) begin
            tmo_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        // rx buffer data lands one cycle after the strobe, i.e. during WR_LOAD
        WR_FETCH: state_q <= WR_LOAD;
        WR_LOAD: begin
          wdata_q <= rx_buf_rdata;
          wr_q    <= 1'b1;
          tcnt_q  <= '0;
          state_q <= WR_REQ;
        end
        WR_REQ: begin
          if (!avmm_waitrequest) begin
            wr_q <= 1'b0;
            if (last_beat) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              beat_q     <= beat_d;
              dw_addr_q  <= dw_addr_d;
              rx_re_q    <= 1'b1;
              rx_raddr_q <= beat_d;
              state_q    <= WR_FETCH;
            end
          end else if (tmo_hit) begin
            wr_q    <= 1'b0;
            tmo_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avmm_addr       = {dw_addr_q, 2'b00};
  assign avmm_read       = rd_q;
  assign avmm_write      = wr_q;
  assign avmm_byteenable = (rd_q || wr_q) ? 4'hf : 4'h0;
  assign avmm_wdata      = wdata_q;
  assign rx_buf_re       = rx_re_q;
  assign rx_buf_raddr    = rx_raddr_q;
  assign tx_buf_we       = tx_we_q;
  assign tx_buf_waddr    = tx_waddr_q;
  assign tx_buf_wdata    = tx_wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_timeout     = tmo_q;
  assign err_overrun     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_auto_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_auto_xfer_ctrl : directed bench with a transaction-level reference
// model and a per-cycle compare process.
// Revision: 1.0
// ============================================================================
module tb_spi_auto_xfer_ctrl;

  localparam int TO = 12;

  logic        avmm_clk = 1'b0;
  logic        rst_avmm_clk;
  logic        auto_update;
  logic [31:0] auto_csr0_reg;
  logic [18:0] avmm_addr;
  logic        avmm_read;
  logic        avmm_write;
  logic [3:0]  avmm_byteenable;
  logic [31:0] avmm_wdata;
  logic [31:0] avmm_rdata;
  logic        avmm_rdatavalid;
  logic        avmm_waitrequest;
  logic        rx_buf_re;
  logic [7:0]  rx_buf_raddr;
  logic [31:0] rx_buf_rdata;
  logic        tx_buf_we;
  logic [7:0]  tx_buf_waddr;
  logic [31:0] tx_buf_wdata;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        err_overrun;

  spi_auto_xfer_ctrl #(.BUF_SIZE(256), .TIMEOUT(TO)) dut (
    .avmm_clk(avmm_clk), .rst_avmm_clk(rst_avmm_clk),
    .auto_update(auto_update), .auto_csr0_reg(auto_csr0_reg),
    .avmm_addr(avmm_addr), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_byteenable(avmm_byteenable), .avmm_wdata(avmm_wdata),
    .avmm_rdata(avmm_rdata), .avmm_rdatavalid(avmm_rdatavalid),
    .avmm_waitrequest(avmm_waitrequest),
    .rx_buf_re(rx_buf_re), .rx_buf_raddr(rx_buf_raddr), .rx_buf_rdata(rx_buf_rdata),
    .tx_buf_we(tx_buf_we), .tx_buf_waddr(tx_buf_waddr), .tx_buf_wdata(tx_buf_wdata),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 avmm_clk = ~avmm_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // slave memory contents as seen by reads
  function automatic logic [31:0] sdata(input logic [16:0] a);
    return (a == 17'h5) ? 32'hDEADBEEF : 32'h1000_0000 + {15'b0, a};
  endfunction

  function automatic logic [31:0] mkcsr(input logic rd, input logic [16:0] a, input logic [7:0] len);
    return {3'b0, len, a, 2'b00, rd, 1'b1};
  endfunction

  logic [31:0] rx_mem [256];
  logic [31:0] tx_mem [256];
  logic [63:0] wr_log [$];
  logic [18:0] rd_log [$];
  int wait_n = 0;
  int rd_lat = 1;
  int cyc = 0, done_cyc = 0, acc_cyc = 0, rd_acc_cyc = 0, tx_cnt = 0;

  // ---------------- slave / buffer responder ----------------
  initial begin : responder
    int wcnt;
    int rcnt;
    logic re_l;
    logic [7:0] ra_l;
    logic acc_rd;
    logic [16:0] acc_a;
    logic [16:0] rd_a;
    wcnt = 0; rcnt = 0; rd_a = '0;
    forever begin
      @(negedge avmm_clk);
      re_l   = rx_buf_re;
      ra_l   = rx_buf_raddr;
      acc_rd = avmm_read & ~avmm_waitrequest;
      acc_a  = avmm_addr[18:2];
      @(posedge avmm_clk); #1;
      avmm_rdatavalid = 1'b0;
      if (rst_avmm_clk) begin
        wcnt = 0; rcnt = 0; avmm_waitrequest = 1'b0;
      end else begin
        if (re_l) rx_buf_rdata = rx_mem[ra_l];
        if (acc_rd && rd_lat != 0) begin rcnt = rd_lat; rd_a = acc_a; end
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin avmm_rdatavalid = 1'b1; avmm_rdata = sdata(rd_a); end
        end
        if (avmm_read || avmm_write) begin
          if (wcnt < wait_n) begin avmm_waitrequest = 1'b1; wcnt++; end
          else begin avmm_waitrequest = 1'b0; wcnt = 0; end
        end else begin
          avmm_waitrequest = 1'b0; wcnt = 0;
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  initial begin : compare
    logic m_busy, m_done, m_tmo, m_ovr, m_wr, m_resp, m_tx_due;
    logic [16:0] m_base;
    int m_beats, m_beat, m_wait, m_tx_idx;
    logic hold_q, hold_r, hold_w;
    logic [18:0] hold_a;
    logic [31:0] hold_d;
    logic busy_now, nx_done, nx_tx, beat_done, tmo_now;
    m_busy = 0; m_done = 0; m_tmo = 0; m_ovr = 0; m_wr = 0; m_resp = 0; m_tx_due = 0;
    m_base = '0; m_beats = 0; m_beat = 0; m_wait = 0; m_tx_idx = 0;
    hold_q = 0; hold_r = 0; hold_w = 0; hold_a = '0; hold_d = '0;
    forever begin
      @(negedge avmm_clk);
      cyc++;
      if (rst_avmm_clk) begin
        check("rst_ctrl", {avmm_read, avmm_write, avmm_byteenable, rx_buf_re, tx_buf_we,
                           busy, done, err_timeout, err_overrun}, 64'h0);
        check("rst_bus", {13'b0, avmm_addr} | avmm_wdata | tx_buf_wdata |
                         {24'b0, rx_buf_raddr} | {24'b0, tx_buf_waddr}, 64'h0);
        m_busy = 0; m_done = 0; m_tmo = 0; m_ovr = 0; m_resp = 0; m_tx_due = 0;
        m_beat = 0; m_wait = 0; hold_q = 0;
      end else begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("err_timeout", err_timeout, m_tmo);
        check("err_overrun", err_overrun, m_ovr);
        check("byteenable", avmm_byteenable, (avmm_read || avmm_write) ? 4'hf : 4'h0);
        check("tx_we", tx_buf_we, m_tx_due);
        if (m_tx_due) begin
          check("tx_waddr", tx_buf_waddr, m_tx_idx[7:0]);
          check("tx_wdata", tx_buf_wdata, sdata(m_base + 17'(m_tx_idx)));
        end
        if (tx_buf_we) begin tx_mem[tx_buf_waddr] = tx_buf_wdata; tx_cnt++; end
        if (rx_buf_re) begin
          check("rx_re_legal", m_busy && m_wr && !m_done, 1);
          check("rx_raddr", rx_buf_raddr, m_beat[7:0]);
        end
        if (avmm_read || avmm_write)
          check("req_legal", m_busy && !m_done && !m_resp && !(avmm_read && avmm_write) &&
                             (avmm_read ? !m_wr : m_wr), 1);
        if (hold_q) begin
          check("hold_req", {avmm_read, avmm_write}, {hold_r, hold_w});
          check("hold_addr", avmm_addr, hold_a);
          if (hold_w) check("hold_wdata", avmm_wdata, hold_d);
        end
        if (avmm_write && !avmm_waitrequest) begin
          check("wr_addr", avmm_addr, {m_base + 17'(m_beat), 2'b00});
          check("wr_data", avmm_wdata, rx_mem[m_beat]);
          wr_log.push_back({13'b0, avmm_addr, avmm_wdata});
          acc_cyc = cyc;
        end
        if (avmm_read && !avmm_waitrequest) begin
          check("rd_addr", avmm_addr, {m_base + 17'(m_beat), 2'b00});
          rd_log.push_back(avmm_addr);
          rd_acc_cyc = cyc;
        end
        if (done) done_cyc = cyc;

        // advance the model to the next cycle's expectations
        busy_now = m_busy; nx_done = 0; nx_tx = 0; beat_done = 0; tmo_now = 0;
        if (auto_update && busy_now) m_ovr = 1;
        if (busy_now && !m_done) begin
          if (avmm_read && !avmm_waitrequest) begin m_resp = 1; m_wait = 0; end
          else if ((avmm_read || avmm_write) && avmm_waitrequest) m_wait++;
          else if (m_resp) begin
            if (avmm_rdatavalid) begin nx_tx = 1; m_tx_idx = m_beat; m_resp = 0; beat_done = 1; end
            else m_wait++;
          end
          if (avmm_write && !avmm_waitrequest) beat_done = 1;
          if (beat_done) begin
            m_beat++; m_wait = 0;
            if (m_beat == m_beats) nx_done = 1;
          end else if (m_wait == TO) begin
            tmo_now = 1; nx_done = 1; m_tmo = 1; m_resp = 0;
          end
        end
        if (m_done) m_busy = 0;
        if (auto_update && !busy_now && auto_csr0_reg[0]) begin
          m_busy = 1; m_ovr = 0; m_tmo = 0; m_resp = 0; m_wait = 0; m_beat = 0;
          m_wr = !auto_csr0_reg[1]; m_base = auto_csr0_reg[20:4];
          m_beats = int'(auto_csr0_reg[28:21]) + 1;
        end
        m_done = nx_done; m_tx_due = nx_tx;
        hold_q = (avmm_read || avmm_write) && avmm_waitrequest && !tmo_now;
        hold_r = avmm_read; hold_w = avmm_write; hold_a = avmm_addr; hold_d = avmm_wdata;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic start(input logic [31:0] csr);
    @(posedge avmm_clk); #1;
    auto_update = 1'b1; auto_csr0_reg = csr;
    @(posedge avmm_clk); #1;
    auto_update = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin @(negedge avmm_clk); n++; end while (!done && n < budget);
    check("done_seen", done, 1);
    @(posedge avmm_clk); #1;
  endtask

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); tx_cnt = 0;
    for (int i = 0; i < 256; i++) tx_mem[i] = '0;
  endtask

  initial begin : stim
    int n;
    rst_avmm_clk = 1'b1; auto_update = 1'b0; auto_csr0_reg = '0;
    avmm_rdata = '0; avmm_rdatavalid = 1'b0; avmm_waitrequest = 1'b0; rx_buf_rdata = '0;
    for (int i = 0; i < 256; i++) begin rx_mem[i] = 32'h0BAD_0000 + i; tx_mem[i] = '0; end
    repeat (3) @(posedge avmm_clk);
    @(negedge avmm_clk);
    check("reset_busy", busy, 0);
    @(posedge avmm_clk); #1;
    rst_avmm_clk = 1'b0;

    // start with valid=0 is ignored
    start(32'h0000_0102);
    repeat (4) @(negedge avmm_clk);
    check("ignored_busy", busy, 0);

    // 3-beat auto-write, no stalls
    clear_logs(); wait_n = 0;
    rx_mem[0] = 32'hAAAA_0001; rx_mem[1] = 32'hBBBB_0002; rx_mem[2] = 32'hCCCC_0003;
    start(mkcsr(1'b0, 17'h10, 8'd2));
    wait_done(60);
    check("w3_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("w3_beat0", wr_log[0], {32'h40, 32'hAAAA_0001});
      check("w3_beat1", wr_log[1], {32'h44, 32'hBBBB_0002});
      check("w3_beat2", wr_log[2], {32'h48, 32'hCCCC_0003});
    end
    check("w3_done_lat", done_cyc - acc_cyc, 1);

    // single auto-read, data 3 cycles after accept
    clear_logs(); rd_lat = 3;
    start(mkcsr(1'b1, 17'h5, 8'd0));
    wait_done(60);
    check("r1_count", rd_log.size(), 1);
    if (rd_log.size() == 1) check("r1_addr", rd_log[0], 19'h14);
    check("r1_txbuf", tx_mem[0], 32'hDEADBEEF);
    check("r1_done_lat", done_cyc - rd_acc_cyc, 4);

    // 2-beat write with 10-cycle stalls on each request
    clear_logs(); wait_n = 10;
    rx_mem[0] = 32'h1111_1111; rx_mem[1] = 32'h2222_2222;
    start(mkcsr(1'b0, 17'h100, 8'd1));
    wait_done(120);
    check("ws_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("ws_beat0", wr_log[0], {32'h400, 32'h1111_1111});
      check("ws_beat1", wr_log[1], {32'h404, 32'h2222_2222});
    end
    check("ws_no_tmo", err_timeout, 0);

    // response never arrives -> timeout abort
    clear_logs(); wait_n = 0; rd_lat = 0;
    start(mkcsr(1'b1, 17'h33, 8'd0));
    wait_done(80);
    check("to_flag", err_timeout, 1);
    check("to_lat", done_cyc - rd_acc_cyc, TO + 1);
    check("to_busy", busy, 0);
    check("to_tx", tx_cnt, 0);

    // overrun during a 4-beat read
    clear_logs(); wait_n = 1; rd_lat = 2;
    start(mkcsr(1'b1, 17'h40, 8'd3));
    repeat (3) @(posedge avmm_clk);
    start(mkcsr(1'b1, 17'h77, 8'd0));
    wait_done(100);
    check("ov_flag", err_overrun, 1);
    check("ov_reads", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) check("ov_txbuf", tx_mem[i], 32'h1000_0040 + i);
    rx_mem[0] = 32'h7777_0000;
    start(mkcsr(1'b0, 17'h7, 8'd0));
    @(negedge avmm_clk);
    check("ov_cleared", err_overrun, 0);
    wait_done(60);

    // reset during beat 1 of a 4-beat read, then address wrap
    clear_logs(); wait_n = 0; rd_lat = 2;
    start(mkcsr(1'b1, 17'h200, 8'd3));
    n = 0;
    while (tx_cnt < 1 && n < 60) begin @(negedge avmm_clk); n++; end
    check("rs_beat0_seen", tx_cnt, 1);
    @(posedge avmm_clk); #1;
    rst_avmm_clk = 1'b1;
    repeat (3) @(posedge avmm_clk);
    #1 rst_avmm_clk = 1'b0;
    clear_logs();
    rx_mem[0] = 32'hE000_0001; rx_mem[1] = 32'hE000_0002;
    start(mkcsr(1'b0, 17'h1FFFF, 8'd1));
    wait_done(60);
    check("wrap_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("wrap_beat0", wr_log[0], {32'h7FFFC, 32'hE000_0001});
      check("wrap_beat1", wr_log[1], {32'h00000, 32'hE000_0002});
    end

    repeat (3) @(posedge avmm_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
